core_clk_rst_seq: RTL and testbench

- Per-domain clock/reset sequencer that sits downstream of the SoC control CSR block.
- Takes the CSR's software requests for PLL feedback divider, clock enable, domain reset and global reset, plus the raw PLL lock status.
- Produces the sequenced divider, clock-gate enable and domain reset that actually drive a core or RAM domain.
- Guarantees the clock is gated while the PLL relocks, and that reset release lags the request. One instance per core and one for RAM.

---
 rtl/soc_pkg.sv | 16 +
 rtl/sync_bit.sv | 28 ++
 rtl/core_clk_rst_seq.sv | 166 ++++++++++++++++
 tb/tb_core_clk_rst_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared types and helpers for the clock/reset sequencer
package soc_pkg;

  typedef enum logic [1:0] {
    SEQ_RESET,
    SEQ_GATE,
    SEQ_LOCK_WAIT,
    SEQ_RUN
  } seq_state_e;

  // Counter width for a count running 0..limit-1; never below one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for a single asynchronous bit
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/core_clk_rst_seq.sv
// rtl/core_clk_rst_seq.sv - per-domain sequencer for PLL divider, clock gate and domain reset
module core_clk_rst_seq
  import soc_pkg::*;
#(
  parameter int FB_DIV_WIDTH = 12,
  parameter int GATE_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 256,
  parameter int RST_REL_DLY  = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [FB_DIV_WIDTH-1:0] fb_div_req_i,
  input  logic                    clk_en_req_i,
  input  logic                    arst_req_i,
  input  logic                    glob_arst_req_i,
  input  logic                    pll_locked_i,
  output logic [FB_DIV_WIDTH-1:0] pll_fb_div_o,
  output logic                    clk_en_o,
  output logic                    arst_o,
  output logic                    locked_o,
  output logic                    busy_o,
  output logic                    lock_err_o,
  output logic                    lock_lost_o
);

  localparam int GW = cnt_w(GATE_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int RW = cnt_w(RST_REL_DLY);

  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(RST_REL_DLY - 1);

  seq_state_e              state_q, state_d;
  logic [GW-1:0]           gate_cnt_q, gate_cnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [RW-1:0]           rel_cnt_q, rel_cnt_d;
  logic [FB_DIV_WIDTH-1:0] fb_div_q, fb_div_d;
  logic                    clk_en_q, clk_en_d;
  logic                    arst_q, arst_d;
  logic                    busy_q, busy_d;
  logic                    lock_err_q, lock_err_d;
  logic                    lock_lost_q, lock_lost_d;
  logic                    locked;
  logic                    rst_req;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .d_i   (pll_locked_i),
    .q_o   (locked)
  );

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    timer_d     = timer_q;
    rel_cnt_d   = rel_cnt_q;
    fb_div_d    = fb_div_q;
    clk_en_d    = clk_en_q;
    arst_d      = arst_q;
    lock_err_d  = lock_err_q;
    lock_lost_d = lock_lost_q;
    rst_req     = arst_req_i | glob_arst_req_i;

    // Reset assertion is honoured in every state; release only happens in RUN.
    if (rst_req) begin
      arst_d    = 1'b1;
      rel_cnt_d = '0;
    end

    case (state_q)
      SEQ_RESET: begin
        clk_en_d   = 1'b0;
        gate_cnt_d = '0;
        state_d    = SEQ_GATE;
      end
      SEQ_GATE: begin
        clk_en_d = 1'b0;
        if (gate_cnt_q == GATE_LAST) begin
          fb_div_d = fb_div_req_i;
          timer_d  = '0;
          state_d  = SEQ_LOCK_WAIT;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
        end
      end
      SEQ_LOCK_WAIT: begin
        clk_en_d = 1'b0;
        if (timer_q != TIME_LAST) begin
          timer_d = timer_q + TW'(1);
        end
        if (locked) begin
          state_d = SEQ_RUN;
        end else if (timer_q == TIME_LAST) begin
          lock_err_d = 1'b1;
          gate_cnt_d = '0;
          state_d    = SEQ_GATE;
        end
      end
      SEQ_RUN: begin
        clk_en_d = clk_en_req_i;
        if (!rst_req) begin
          if (rel_cnt_q == REL_LAST) begin
            arst_d = 1'b0;
          end else begin
            rel_cnt_d = rel_cnt_q + RW'(1);
          end
        end
        if (fb_div_req_i != fb_div_q) begin
          clk_en_d   = 1'b0;
          gate_cnt_d = '0;
          state_d    = SEQ_GATE;
        end else if (!locked) begin
          clk_en_d    = 1'b0;
          lock_lost_d = 1'b1;
          timer_d     = '0;
          state_d     = SEQ_LOCK_WAIT;
        end
      end
      default: begin
        state_d = SEQ_RESET;
      end
    endcase

    busy_d = (state_d != SEQ_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= SEQ_RESET;
      gate_cnt_q  <= '0;
      timer_q     <= '0;
      rel_cnt_q   <= '0;
      fb_div_q    <= '0;
      clk_en_q    <= 1'b0;
      arst_q      <= 1'b1;
      busy_q      <= 1'b1;
      lock_err_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      timer_q     <= timer_d;
      rel_cnt_q   <= rel_cnt_d;
      fb_div_q    <= fb_div_d;
      clk_en_q    <= clk_en_d;
      arst_q      <= arst_d;
      busy_q      <= busy_d;
      lock_err_q  <= lock_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_fb_div_o = fb_div_q;
  assign clk_en_o     = clk_en_q;
  assign arst_o       = arst_q;
  assign locked_o     = locked;
  assign busy_o       = busy_q;
  assign lock_err_o   = lock_err_q;
  assign lock_lost_o  = lock_lost_q;

endmodule

// File: tb/tb_core_clk_rst_seq.sv
// tb/tb_core_clk_rst_seq.sv - self-checking bench for core_clk_rst_seq
module tb_core_clk_rst_seq;

  typedef enum int {S_DIV, S_CLKEN, S_ARST, S_LOCKED, S_BUSY, S_ERR, S_LOST} sig_e;

  typedef struct {
    int    due;
    string name;
    sig_e  sig;
    int    exp;
  } sb_entry_t;

  typedef struct {
    logic use_glob;
    int   gap;
    int   exp_pre;
    int   exp_mid;
    int   fall_dly;
  } rel_vec_t;

  logic        clk = 1'b0;
  logic        srst_i;
  logic [11:0] fb_div_req_i;
  logic        clk_en_req_i;
  logic        arst_req_i;
  logic        glob_arst_req_i;
  logic        pll_locked_i;
  logic [11:0] pll_fb_div_o;
  logic        clk_en_o;
  logic        arst_o;
  logic        locked_o;
  logic        busy_o;
  logic        lock_err_o;
  logic        lock_lost_o;

  int        cyc = 0;
  int        n_checks = 0;
  int        n_pass = 0;
  sb_entry_t sb[$];
  rel_vec_t  rel_tbl[4];

  core_clk_rst_seq dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .fb_div_req_i   (fb_div_req_i),
    .clk_en_req_i   (clk_en_req_i),
    .arst_req_i     (arst_req_i),
    .glob_arst_req_i(glob_arst_req_i),
    .pll_locked_i   (pll_locked_i),
    .pll_fb_div_o   (pll_fb_div_o),
    .clk_en_o       (clk_en_o),
    .arst_o         (arst_o),
    .locked_o       (locked_o),
    .busy_o         (busy_o),
    .lock_err_o     (lock_err_o),
    .lock_lost_o    (lock_lost_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act_of(input sig_e s);
    case (s)
      S_DIV:    return int'(pll_fb_div_o);
      S_CLKEN:  return int'(clk_en_o);
      S_ARST:   return int'(arst_o);
      S_LOCKED: return int'(locked_o);
      S_BUSY:   return int'(busy_o);
      S_ERR:    return int'(lock_err_o);
      default:  return int'(lock_lost_o);
    endcase
  endfunction

  // Outputs are compared on the falling edge, when their due cycle comes up.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_checks++;
        if (act_of(sb[i].sig) == sb[i].exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h",
                   sb[i].name, cyc, act_of(sb[i].sig), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic sb_push(input string name, input sig_e sig, input int exp, input int dly);
    sb_entry_t e;
    e.due  = cyc + dly;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release srst_i with lock already present and track the bring-up timeline.
  task automatic power_up(input int div);
    srst_i = 1'b0;
    sb_push("pu_locked_pre", S_LOCKED, 0, 1);
    sb_push("pu_locked", S_LOCKED, 1, 2);
    sb_push("pu_div_pre", S_DIV, 0, 4);
    sb_push("pu_div", S_DIV, div, 5);
    sb_push("pu_busy_lw", S_BUSY, 1, 5);
    sb_push("pu_busy_run", S_BUSY, 0, 6);
    sb_push("pu_clken_pre", S_CLKEN, 0, 6);
    sb_push("pu_clken", S_CLKEN, 1, 7);
    sb_push("pu_arst_hold", S_ARST, 1, 13);
    sb_push("pu_arst_rel", S_ARST, 0, 14);
    step(20);
  endtask

  task automatic set_req(input logic use_glob, input logic v);
    if (use_glob) glob_arst_req_i = v;
    else arst_req_i = v;
  endtask

  initial begin
    rel_tbl[0] = '{use_glob: 1'b0, gap: 3, exp_pre: 0, exp_mid: 1, fall_dly: 8};
    rel_tbl[1] = '{use_glob: 1'b1, gap: 3, exp_pre: 0, exp_mid: 1, fall_dly: 8};
    rel_tbl[2] = '{use_glob: 1'b0, gap: 7, exp_pre: 0, exp_mid: 1, fall_dly: 8};
    rel_tbl[3] = '{use_glob: 1'b1, gap: 0, exp_pre: 0, exp_mid: 1, fall_dly: 8};

    srst_i          = 1'b1;
    fb_div_req_i    = 12'h020;
    clk_en_req_i    = 1'b1;
    arst_req_i      = 1'b0;
    glob_arst_req_i = 1'b0;
    pll_locked_i    = 1'b1;
    step(3);

    n_checks++;
    if (busy_o == 1'b1) n_pass++;
    else $display("FAIL rst_busy_direct: got %0b", busy_o);
    n_checks++;
    if (arst_o == 1'b1) n_pass++;
    else $display("FAIL rst_arst_direct: got %0b", arst_o);

    sb_push("rst_div", S_DIV, 0, 0);
    sb_push("rst_clken", S_CLKEN, 0, 0);
    sb_push("rst_arst", S_ARST, 1, 0);
    sb_push("rst_busy", S_BUSY, 1, 0);
    sb_push("rst_err", S_ERR, 0, 0);
    sb_push("rst_lost", S_LOST, 0, 0);
    sb_push("rst_locked", S_LOCKED, 0, 0);
    step(1);

    power_up(12'h020);

    n_checks++;
    if (pll_fb_div_o == 12'h020) n_pass++;
    else $display("FAIL pu_div_direct: got 0x%0h", pll_fb_div_o);
    n_checks++;
    if (clk_en_o == 1'b1) n_pass++;
    else $display("FAIL pu_clken_direct: got %0b", clk_en_o);
    n_checks++;
    if (busy_o == 1'b0) n_pass++;
    else $display("FAIL pu_busy_direct: got %0b", busy_o);
    n_checks++;
    if (arst_o == 1'b0) n_pass++;
    else $display("FAIL pu_arst_direct: got %0b", arst_o);

    // Double reset-request pulses: release trails the last pulse.
    foreach (rel_tbl[r]) begin
      sb_push("rel_pre", S_ARST, rel_tbl[r].exp_pre, 0);
      set_req(rel_tbl[r].use_glob, 1'b1);
      step(1);
      set_req(rel_tbl[r].use_glob, 1'b0);
      sb_push("rel_first", S_ARST, 1, 0);
      step(rel_tbl[r].gap);
      sb_push("rel_mid", S_ARST, rel_tbl[r].exp_mid, 0);
      set_req(rel_tbl[r].use_glob, 1'b1);
      step(1);
      set_req(rel_tbl[r].use_glob, 1'b0);
      sb_push("rel_hold", S_ARST, 1, rel_tbl[r].fall_dly - 1);
      sb_push("rel_fall", S_ARST, 0, rel_tbl[r].fall_dly);
      step(12);
    end

    // Divider change while lock drops for 20 cycles.
    fb_div_req_i = 12'h040;
    pll_locked_i = 1'b0;
    sb_push("dc_clken_off", S_CLKEN, 0, 1);
    sb_push("dc_div_old", S_DIV, 12'h020, 4);
    sb_push("dc_div_new", S_DIV, 12'h040, 5);
    sb_push("dc_lost_mid", S_LOST, 0, 5);
    step(20);
    pll_locked_i = 1'b1;
    sb_push("dc_busy_wait", S_BUSY, 1, 2);
    sb_push("dc_busy_run", S_BUSY, 0, 3);
    sb_push("dc_clken_wait", S_CLKEN, 0, 3);
    sb_push("dc_clken_on", S_CLKEN, 1, 4);
    sb_push("dc_lost_end", S_LOST, 0, 4);
    sb_push("dc_err_end", S_ERR, 0, 4);
    step(10);

    // Lock loss in RUN.
    pll_locked_i = 1'b0;
    sb_push("ll_lost_pre", S_LOST, 0, 2);
    sb_push("ll_clken_pre", S_CLKEN, 1, 2);
    sb_push("ll_lost", S_LOST, 1, 3);
    sb_push("ll_clken_off", S_CLKEN, 0, 3);
    sb_push("ll_busy", S_BUSY, 1, 3);
    step(5);
    pll_locked_i = 1'b1;
    sb_push("ll_busy_run", S_BUSY, 0, 3);
    sb_push("ll_clken_on", S_CLKEN, 1, 4);
    sb_push("ll_div_kept", S_DIV, 12'h040, 4);
    sb_push("ll_lost_sticky", S_LOST, 1, 4);
    step(10);

    // Lock timeout with retries; a divider change is only taken at the end of GATE.
    pll_locked_i = 1'b0;
    sb_push("to_err_pre", S_ERR, 0, 258);
    sb_push("to_err", S_ERR, 1, 259);
    sb_push("to_busy", S_BUSY, 1, 259);
    step(100);
    fb_div_req_i = 12'h055;
    sb_push("to_div_lw", S_DIV, 12'h040, 100);
    sb_push("to_div_gate", S_DIV, 12'h040, 162);
    sb_push("to_div_retry", S_DIV, 12'h055, 163);
    sb_push("to_err_sticky", S_ERR, 1, 300);
    step(421);

    // Synchronous reset in the middle of the second retry's GATE.
    sb_push("mr_err_pre", S_ERR, 1, 0);
    sb_push("mr_lost_pre", S_LOST, 1, 0);
    sb_push("mr_arst_pre", S_ARST, 0, 0);
    srst_i       = 1'b1;
    pll_locked_i = 1'b1;
    sb_push("mr_div", S_DIV, 0, 1);
    sb_push("mr_arst", S_ARST, 1, 1);
    sb_push("mr_clken", S_CLKEN, 0, 1);
    sb_push("mr_err", S_ERR, 0, 1);
    sb_push("mr_lost", S_LOST, 0, 1);
    sb_push("mr_busy", S_BUSY, 1, 1);
    sb_push("mr_div_hold", S_DIV, 0, 2);
    step(3);

    power_up(12'h055);
    sb_push("end_err", S_ERR, 0, 0);
    sb_push("end_lost", S_LOST, 0, 0);
    step(2);

    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s: never compared (due cycle %0d)", sb[i].name, sb[i].due);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
